// File: rtl/ff_excitation_gen.sv
// Excitation generator: derives SR/JK/D/T excitations that move the current state to a
// requested target, applies them to four flop banks, and checks every bank reached it.
module ff_excitation_gen #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] tgt_q,
    input  logic [WIDTH-1:0] inj_flip,
    output logic [WIDTH-1:0] s_o,
    output logic [WIDTH-1:0] r_o,
    output logic [WIDTH-1:0] j_o,
    output logic [WIDTH-1:0] k_o,
    output logic [WIDTH-1:0] d_o,
    output logic [WIDTH-1:0] t_o,
    output logic [WIDTH-1:0] q_sr,
    output logic [WIDTH-1:0] q_jk,
    output logic [WIDTH-1:0] q_d,
    output logic [WIDTH-1:0] q_t,
    output logic             done,
    output logic             mismatch,
    output logic [7:0]       xfer_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] tgt_cap;
    logic             accept;
    logic             banks_off;

    assign tgt_ready = (state == IDLE) && !rst;
    assign accept    = tgt_valid && tgt_ready;
    assign banks_off = (q_sr != tgt_cap) || (q_jk != tgt_cap) ||
                       (q_d != tgt_cap) || (q_t != tgt_cap);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = APPLY;
                end else begin
                    state_nxt = IDLE;
                end
            end
            APPLY:   state_nxt = CHECK;
            CHECK:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Excitation registers, flop banks, status and transfer counter
    always_ff @(posedge clk) begin
        if (rst) begin
            tgt_cap  <= {WIDTH{1'b0}};
            s_o      <= {WIDTH{1'b0}};
            r_o      <= {WIDTH{1'b0}};
            j_o      <= {WIDTH{1'b0}};
            k_o      <= {WIDTH{1'b0}};
            d_o      <= {WIDTH{1'b0}};
            t_o      <= {WIDTH{1'b0}};
            q_sr     <= {WIDTH{1'b0}};
            q_jk     <= {WIDTH{1'b0}};
            q_d      <= {WIDTH{1'b0}};
            q_t      <= {WIDTH{1'b0}};
            done     <= 1'b0;
            mismatch <= 1'b0;
            xfer_cnt <= 8'd0;
        end else begin
            // Banks follow their excitations every cycle; idle excitations make them hold.
            // S=R=1 is treated as hold here and flagged below.
            q_sr <= (s_o & ~r_o) | (q_sr & ~(r_o & ~s_o));
            q_jk <= (j_o & ~q_jk) | (~k_o & q_jk);
            q_d  <= d_o;
            q_t  <= q_t ^ t_o;

            if (accept) begin
                tgt_cap <= tgt_q;
                s_o     <= ~q_d & tgt_q;
                r_o     <= q_d & ~tgt_q;
                j_o     <= ~q_d & tgt_q;
                k_o     <= q_d & ~tgt_q;
                d_o     <= tgt_q;
                t_o     <= (q_d ^ tgt_q) ^ inj_flip;
            end else begin
                // d_o already equals the value q_d is loading, so holding it keeps d_o == q_d.
                s_o <= {WIDTH{1'b0}};
                r_o <= {WIDTH{1'b0}};
                j_o <= {WIDTH{1'b0}};
                k_o <= {WIDTH{1'b0}};
                t_o <= {WIDTH{1'b0}};
            end

            done <= (state == APPLY);

            if ((state == APPLY) && (xfer_cnt != 8'd255)) begin
                xfer_cnt <= xfer_cnt + 8'd1;
            end else begin
                xfer_cnt <= xfer_cnt;
            end

            if ((|(s_o & r_o)) || ((state == CHECK) && banks_off)) begin
                mismatch <= 1'b1;
            end else begin
                mismatch <= mismatch;
            end
        end
    end

endmodule
